ibar_writeback: RTL



---
 rtl/ibar_pkg.sv | 24 ++
 rtl/ibar_wb_linebuf.sv | 69 ++++++
 rtl/ibar_writeback.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ibar_pkg.sv
// Shared definitions for the ibar writeback engine: FSM state encoding,
// default geometry of the D-cache arrays and the line address builder.
package ibar_pkg;

    localparam int IBAR_INDEX_W  = 6;
    localparam int IBAR_TAG_W    = 20;
    localparam int IBAR_OFFSET_W = 6;
    localparam int IBAR_LINE_W   = 512;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_SEND = 3'd3,
        ST_ACK  = 3'd4
    } ibar_state_e;

    // Line-aligned byte address {tag, index, zero offset}.
    function automatic logic [31:0] line_addr(input logic [IBAR_TAG_W-1:0]   tag,
                                              input logic [IBAR_INDEX_W-1:0] index);
        return {tag, index, {IBAR_OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/ibar_wb_linebuf.sv
// Two-entry {tag, data} line buffer for one cache set plus the way-select
// mux that feeds the memory write port.
module ibar_wb_linebuf
    import ibar_pkg::*;
#(
    parameter int INDEX_W  = IBAR_INDEX_W,
    parameter int TAG_W    = IBAR_TAG_W,
    parameter int OFFSET_W = IBAR_OFFSET_W,
    parameter int LINE_W   = IBAR_LINE_W
) (
    input  logic                              clk,
    input  logic                              load,
    input  logic                              sel,
    input  logic [INDEX_W-1:0]                index,
    input  logic [TAG_W-1:0]                  tag_in0,
    input  logic [TAG_W-1:0]                  tag_in1,
    input  logic [LINE_W-1:0]                 data_in0,
    input  logic [LINE_W-1:0]                 data_in1,
    output logic [TAG_W+INDEX_W+OFFSET_W-1:0] wr_addr,
    output logic [LINE_W-1:0]                 wr_data
);

    logic [TAG_W-1:0]  tag0_q,  tag0_d;
    logic [TAG_W-1:0]  tag1_q,  tag1_d;
    logic [LINE_W-1:0] data0_q, data0_d;
    logic [LINE_W-1:0] data1_q, data1_d;

    // Capture both ways on the load strobe, otherwise hold the buffered set.
    always_comb begin
        tag0_d  = tag0_q;
        tag1_d  = tag1_q;
        data0_d = data0_q;
        data1_d = data1_q;
        if (load) begin
            tag0_d  = tag_in0;
            tag1_d  = tag_in1;
            data0_d = data_in0;
            data1_d = data_in1;
        end else begin
            tag0_d  = tag0_q;
            tag1_d  = tag1_q;
            data0_d = data0_q;
            data1_d = data1_q;
        end
    end

    // Buffer storage; contents are only meaningful while the FSM is in SEND,
    // so no reset is needed on this wide datapath.
    always_ff @(posedge clk) begin
        tag0_q  <= tag0_d;
        tag1_q  <= tag1_d;
        data0_q <= data0_d;
        data1_q <= data1_d;
    end

    // Select the way currently being written back (0 = way 0, 1 = way 1).
    always_comb begin
        wr_addr = line_addr(tag0_q, index);
        wr_data = data0_q;
        if (sel) begin
            wr_addr = line_addr(tag1_q, index);
            wr_data = data1_q;
        end else begin
            wr_addr = line_addr(tag0_q, index);
            wr_data = data0_q;
        end
    end

endmodule

// File: rtl/ibar_writeback.sv
// Writeback engine for the ibar dirty-line walk. Reads one dirty set from the
// tag/data arrays and writes each dirty way (way 0 first) to memory, then
// pulses ibar_ready. Optional line counter enabled by IBAR_WB_PERF_EN.
module ibar_writeback
    import ibar_pkg::*;
#(
    parameter int INDEX_W  = IBAR_INDEX_W,
    parameter int TAG_W    = IBAR_TAG_W,
    parameter int OFFSET_W = IBAR_OFFSET_W,
    parameter int LINE_W   = IBAR_LINE_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ibar_valid,
    input  logic [INDEX_W-1:0]                dirty_addr,
    input  logic                              way0,
    input  logic                              way1,
    output logic                              ibar_ready,
    output logic [INDEX_W-1:0]                ram_raddr,
    output logic                              ram_ren,
    input  logic [TAG_W-1:0]                  tag_rdata0,
    input  logic [TAG_W-1:0]                  tag_rdata1,
    input  logic [LINE_W-1:0]                 data_rdata0,
    input  logic [LINE_W-1:0]                 data_rdata1,
    output logic                              wr_req,
    output logic [TAG_W+INDEX_W+OFFSET_W-1:0] wr_addr,
    output logic [LINE_W-1:0]                 wr_data,
    input  logic                              wr_rdy,
    output logic                              busy,
    output logic [31:0]                       wb_line_cnt
);

    ibar_state_e        state_q, state_d;
    logic [INDEX_W-1:0] set_q,   set_d;
    logic [1:0]         mask_q,  mask_d;
    logic               buf_load;
    logic               way_sel;

    // Lowest dirty way first: way 1 is selected only once way 0 is clean.
    assign way_sel = ~mask_q[0];

    // Next-state, mask bookkeeping and control outputs.
    always_comb begin
        state_d    = state_q;
        set_d      = set_q;
        mask_d     = mask_q;
        ram_ren    = 1'b0;
        ram_raddr  = dirty_addr;
        buf_load   = 1'b0;
        wr_req     = (state_q == ST_SEND);
        ibar_ready = (state_q == ST_ACK);
        busy       = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (ibar_valid) begin
                    set_d   = dirty_addr;
                    mask_d  = {way1, way0};
                    ram_ren = 1'b1;
                    state_d = ST_RD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                // Array outputs are valid now; the buffer is full on entering CAP.
                buf_load = 1'b1;
                state_d  = ST_CAP;
            end
            ST_CAP: begin
                if (mask_q == 2'b00) begin
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (wr_rdy) begin
                    if (way_sel) begin
                        mask_d = {1'b0, mask_q[0]};
                    end else begin
                        mask_d = {mask_q[1], 1'b0};
                    end
                    if (mask_d == 2'b00) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                mask_d  = 2'b00;
            end
        endcase
    end

    // FSM, set index and dirty mask registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            set_q   <= {INDEX_W{1'b0}};
            mask_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            mask_q  <= mask_d;
        end
    end

    ibar_wb_linebuf #(
        .INDEX_W  (INDEX_W),
        .TAG_W    (TAG_W),
        .OFFSET_W (OFFSET_W),
        .LINE_W   (LINE_W)
    ) u_linebuf (
        .clk      (clk),
        .load     (buf_load),
        .sel      (way_sel),
        .index    (set_q),
        .tag_in0  (tag_rdata0),
        .tag_in1  (tag_rdata1),
        .data_in0 (data_rdata0),
        .data_in1 (data_rdata1),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

`ifdef IBAR_WB_PERF_EN
    logic [31:0] cnt_q, cnt_d;

    // Saturating count of accepted line writes.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_req && wr_rdy && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wb_line_cnt = cnt_q;
`else
    assign wb_line_cnt = 32'd0;
`endif

endmodule
